adder_scheduler: RTL and testbench

ADDER_SCHEDULER -- requirements
Module: adder_scheduler

---
 rtl/adder_scheduler_if.sv | 25 ++
 rtl/adder_scheduler.sv | 78 +++++++
 tb/tb_adder_scheduler.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/adder_scheduler_if.sv
// adder_scheduler_if: request and result handshake bundle for adder_scheduler.
interface adder_scheduler_if #(
    parameter int N    = 24,
    parameter int REQS = 4
);
    localparam int IW = $clog2(REQS);
    logic [REQS-1:0]   req_valid;
    logic [REQS-1:0]   req_ready;
    logic [REQS*N-1:0] req_a;
    logic [REQS*N-1:0] req_b;
    logic [REQS-1:0]   req_sub;
    logic              res_valid;
    logic              res_ready;
    logic [IW-1:0]     res_id;
    logic [N-1:0]      res_r;
    logic [3:0]        res_flags;
    modport master (
        output req_valid, req_a, req_b, req_sub, res_ready,
        input  req_ready, res_valid, res_id, res_r, res_flags
    );
    modport slave (
        input  req_valid, req_a, req_b, req_sub, res_ready,
        output req_ready, res_valid, res_id, res_r, res_flags
    );
endinterface

// File: rtl/adder_scheduler.sv
// adder_scheduler: round-robin arbiter sharing one ripple adder/subtractor
// among REQS requesters, one operation in flight at a time.
module adder_scheduler #(
    parameter int N    = 24,
    parameter int REQS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    adder_scheduler_if.slave bus,
    output logic          busy_o
);
    localparam int IW = $clog2(REQS);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, gnt, id_q, res_id_q;
    logic [N-1:0]  a_q, b_q, bo, sum, res_r_q;
    logic [N:0]    c;
    logic [3:0]    flags, flags_q;
    logic          sub_q, any, take;
    // The lowest offset from the pointer is written last, so it wins.
    always_comb begin
        any = 1'b0;
        gnt = '0;
        for (int i = REQS - 1; i >= 0; i--) begin
            if (bus.req_valid[(int'(ptr_q) + i) % REQS]) begin
                any = 1'b1;
                gnt = IW'((int'(ptr_q) + i) % REQS);
            end
        end
    end
    assign take = (state_q == IDLE) && any;
    assign bus.req_ready = (rst_n && take) ? (REQS'(1) << gnt) : '0;
    assign bo = sub_q ? ~b_q : b_q;
    assign c[0] = sub_q;
    for (genvar k = 0; k < N; k++) begin : g_rca
        assign sum[k]   = a_q[k] ^ bo[k] ^ c[k];
        assign c[k+1]   = (a_q[k] & bo[k]) | (c[k] & (a_q[k] ^ bo[k]));
    end
    // Comparing against the inverted B makes one overflow rule cover add and sub.
    assign flags = {~|sum, sum[N-1], c[N], (a_q[N-1] == bo[N-1]) && (sum[N-1] != a_q[N-1])};
    always_comb begin
        state_d = (state_q == IDLE) ? (any ? EXEC : IDLE) :
                  (state_q == EXEC) ? DONE :
                  (state_q == DONE && !bus.res_ready) ? DONE : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            id_q     <= '0;
            res_r_q  <= '0;
            flags_q  <= '0;
            res_id_q <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                a_q   <= bus.req_a[int'(gnt)*N +: N];
                b_q   <= bus.req_b[int'(gnt)*N +: N];
                sub_q <= bus.req_sub[gnt];
                id_q  <= gnt;
                ptr_q <= (gnt == IW'(REQS - 1)) ? '0 : gnt + 1'b1;
            end
            if (state_q == EXEC) begin
                res_r_q  <= sum;
                flags_q  <= flags;
                res_id_q <= id_q;
            end
        end
    end
    assign bus.res_valid = (state_q == DONE);
    assign bus.res_r     = res_r_q;
    assign bus.res_flags = flags_q;
    assign bus.res_id    = res_id_q;
    assign busy_o        = (state_q != IDLE);
endmodule

// File: tb/tb_adder_scheduler.sv
// tb_adder_scheduler: scoreboard bench for adder_scheduler; expected results are
// queued at grant time from an arithmetic model and compared on result handshake.
module tb_adder_scheduler;
    localparam int N = 24;
    localparam int REQS = 4;
    typedef struct packed {
        logic [1:0]   id;
        logic [N-1:0] r;
        logic [3:0]   f;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    exp_t sbq[$];
    exp_t e;
    int n_checks = 0, n_fail = 0, mptr = 0, cyc = 0, g;
    logic [N-1:0] opa[REQS], opb[REQS];
    logic ops[REQS];
    always #5 clk = ~clk;
    adder_scheduler_if #(.N(N), .REQS(REQS)) bus();
    adder_scheduler #(.N(N), .REQS(REQS)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave), .busy_o(busy)
    );
    always_comb begin
        for (int i = 0; i < REQS; i++) begin
            bus.req_a[i*N +: N] = opa[i];
            bus.req_b[i*N +: N] = opb[i];
            bus.req_sub[i]      = ops[i];
        end
    end
    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    function automatic exp_t model(int id, logic [N-1:0] a, logic [N-1:0] b, logic sub);
        exp_t m;
        longint sa, sbv, sr;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        sr  = sub ? sa - sbv : sa + sbv;
        m.id = 2'(id);
        m.r  = sub ? a - b : a + b;
        m.f  = {m.r == '0, m.r[N-1],
                sub ? (a >= b) : (longint'(a) + longint'(b) >= (longint'(1) << N)),
                (sr > (longint'(1) << (N-1)) - 1) || (sr < -(longint'(1) << (N-1)))};
        return m;
    endfunction
    function automatic int rr(logic [REQS-1:0] v, int p);
        for (int i = 0; i < REQS; i++) if (v[(p + i) % REQS]) return (p + i) % REQS;
        return -1;
    endfunction
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            sbq.delete();
            mptr = 0;
        end else begin
            if (bus.req_ready != '0) begin
                g = rr(bus.req_valid, mptr);
                if (g < 0) check("grant_without_valid", 32'(bus.req_ready), 0);
                else begin
                    check("rr_grant", 32'(bus.req_ready), 32'(1) << g);
                    sbq.push_back(model(g, opa[g], opb[g], ops[g]));
                    mptr = (g + 1) % REQS;
                end
            end
            if (bus.res_valid && bus.res_ready) begin
                check("sb_nonempty", (sbq.size() != 0) ? 1 : 0, 1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    check("res_id", 32'(bus.res_id), 32'(e.id));
                    check("res_r", 32'(bus.res_r), 32'(e.r));
                    check("res_flags", 32'(bus.res_flags), 32'(e.f));
                end
            end
        end
    end
    task automatic set_op(int r, logic [N-1:0] a, logic [N-1:0] b, logic s);
        opa[r] = a;
        opb[r] = b;
        ops[r] = s;
    endtask
    task automatic wait_grant(int r, output int at);
        bit ok = 0;
        at = -1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bus.req_ready[r]) begin
                ok = 1;
                at = cyc;
            end
        end
        if (!ok) check("grant_timeout", 32'(bus.req_ready), 32'(1) << r);
    endtask
    task automatic do_op(int r, logic [N-1:0] a, logic [N-1:0] b, logic s, bit mutate,
                         logic [N-1:0] er, logic [3:0] ef);
        int at;
        @(posedge clk); #1;
        set_op(r, a, b, s);
        bus.req_valid[r] = 1'b1;
        wait_grant(r, at);
        @(posedge clk); #1;
        bus.req_valid[r] = 1'b0;
        if (mutate) opa[r] = ~a;
        @(negedge clk);
        check("lat_exec_valid", 32'(bus.res_valid), 0);
        check("busy_exec", 32'(busy), 1);
        @(negedge clk);
        check("lat_done_valid", 32'(bus.res_valid), 1);
        check("spec_r", 32'(bus.res_r), 32'(er));
        check("spec_flags", 32'(bus.res_flags), 32'(ef));
        check("spec_id", 32'(bus.res_id), r);
    endtask
    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask
    int at, prev;
    int seq[6] = '{0, 1, 2, 3, 0, 1};
    initial begin
        for (int i = 0; i < REQS; i++) set_op(i, '0, '0, 1'b0);
        bus.res_ready = 1'b1;
        bus.req_valid = '1;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 0);
        check("rst_res_valid", 32'(bus.res_valid), 0);
        check("rst_res_r", 32'(bus.res_r), 0);
        check("rst_res_flags", 32'(bus.res_flags), 0);
        check("rst_res_id", 32'(bus.res_id), 0);
        check("rst_busy", 32'(busy), 0);
        bus.req_valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_op(0, 24'h000005, 24'h000003, 1'b0, 0, 24'h000008, 4'b0000);
        do_op(0, 24'h000005, 24'h000003, 1'b1, 0, 24'h000002, 4'b0010);
        do_op(0, 24'h7FFFFF, 24'h000001, 1'b0, 0, 24'h800000, 4'b0101);
        do_op(0, 24'h123456, 24'h123456, 1'b1, 0, 24'h000000, 4'b1010);
        do_op(0, 24'h000000, 24'h000001, 1'b1, 0, 24'hFFFFFF, 4'b0100);
        do_op(2, 24'h000100, 24'h0000FF, 1'b0, 1, 24'h0001FF, 4'b0000);
        // Round robin with every requester held valid from reset.
        for (int i = 0; i < REQS; i++) set_op(i, 24'(32'h111111 * (i + 1)), 24'(32'h010203 * i), 1'(i));
        bus.req_valid = '1;
        do_reset();
        prev = -1;
        for (int k = 0; k < 6; k++) begin
            wait_grant(seq[k], at);
            if (prev >= 0) check("rr_gap", at - prev, 3);
            prev = at;
            if (k == 5) begin
                @(posedge clk); #1;
                bus.req_valid = '0;
            end
            @(negedge clk);
            check("ready_pulse", 32'(bus.req_ready), 0);
        end
        repeat (4) @(negedge clk);
        do_op(2, 24'h000010, 24'h000001, 1'b0, 0, 24'h000011, 4'b0000);
        do_op(2, 24'h000020, 24'h000001, 1'b1, 0, 24'h00001F, 4'b0010);
        @(posedge clk); #1;
        set_op(0, 24'h000003, 24'h000004, 1'b0);
        set_op(3, 24'h400000, 24'h400000, 1'b0);
        bus.req_valid[0] = 1'b1;
        bus.req_valid[3] = 1'b1;
        wait_grant(3, at);
        @(posedge clk); #1;
        bus.req_valid[3] = 1'b0;
        wait_grant(0, at);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        repeat (4) @(negedge clk);
        // Backpressure: result must hold while the consumer stalls.
        bus.res_ready = 1'b0;
        @(posedge clk); #1;
        set_op(1, 24'h000010, 24'h000020, 1'b1);
        bus.req_valid[1] = 1'b1;
        wait_grant(1, at);
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        set_op(0, 24'h00ABCD, 24'h001111, 1'b0);
        bus.req_valid[0] = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(bus.res_valid), 1);
            check("bp_r", 32'(bus.res_r), 32'h00FFFFF0);
            check("bp_flags", 32'(bus.res_flags), 4'b0100);
            check("bp_id", 32'(bus.res_id), 1);
            check("bp_no_ready", 32'(bus.req_ready), 0);
        end
        @(posedge clk); #1;
        bus.res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_idle_busy", 32'(busy), 0);
        check("bp_idle_grant", 32'(bus.req_ready), 1);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_abort_r", 32'(bus.res_r), 32'h00BCDE);
        // Reset during EXEC abandons the operation asynchronously.
        @(posedge clk); #1;
        set_op(3, 24'h000001, 24'h000002, 1'b0);
        bus.req_valid[3] = 1'b1;
        wait_grant(3, at);
        @(posedge clk); #1;
        bus.req_valid[3] = 1'b0;
        #2;
        rst_n = 1'b0;
        bus.req_valid = '1;
        #1;
        check("abort_res_valid", 32'(bus.res_valid), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_req_ready", 32'(bus.req_ready), 0);
        check("abort_res_r", 32'(bus.res_r), 0);
        check("abort_res_flags", 32'(bus.res_flags), 0);
        check("abort_res_id", 32'(bus.res_id), 0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_grant(0, at);
        @(posedge clk); #1;
        bus.req_valid = '0;
        repeat (6) @(negedge clk);
        check("sb_drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
